// File: rtl/axi_parameters.sv
// Shared AXI4 widths and the write-arbiter state encoding.
package axi_parameters;

  localparam int unsigned ID_WIDTH   = 4;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t ADDR = 2'd1;
  localparam arb_state_t DATA = 2'd2;
  localparam arb_state_t RESP = 2'd3;

endpackage

// File: rtl/axi4_wr_arbiter_if.sv
// Master-side request arrays and slave-side write channels of the write arbiter.
interface axi4_wr_arbiter_if #(
  parameter int unsigned NUM_M = 2
);
  import axi_parameters::*;

  logic [NUM_M*ID_WIDTH-1:0]     m_awid;
  logic [NUM_M*ADDR_WIDTH-1:0]   m_awaddr;
  logic [NUM_M*8-1:0]            m_awlen;
  logic [NUM_M*3-1:0]            m_awsize;
  logic [NUM_M*2-1:0]            m_awburst;
  logic [NUM_M-1:0]              m_awvalid;
  logic [NUM_M-1:0]              m_awready;
  logic [NUM_M*DATA_WIDTH-1:0]   m_wdata;
  logic [NUM_M*DATA_WIDTH/8-1:0] m_wstrb;
  logic [NUM_M-1:0]              m_wlast;
  logic [NUM_M-1:0]              m_wvalid;
  logic [NUM_M-1:0]              m_wready;
  logic [ID_WIDTH-1:0]           m_bid;
  logic [1:0]                    m_bresp;
  logic [NUM_M-1:0]              m_bvalid;
  logic [NUM_M-1:0]              m_bready;

  logic [ID_WIDTH-1:0]           s_awid;
  logic [ADDR_WIDTH-1:0]         s_awaddr;
  logic [7:0]                    s_awlen;
  logic [2:0]                    s_awsize;
  logic [1:0]                    s_awburst;
  logic                          s_awlock;
  logic [3:0]                    s_awcache;
  logic [2:0]                    s_awprot;
  logic [3:0]                    s_awqos;
  logic                          s_awvalid;
  logic                          s_awready;
  logic [DATA_WIDTH-1:0]         s_wdata;
  logic [DATA_WIDTH/8-1:0]       s_wstrb;
  logic                          s_wlast;
  logic                          s_wvalid;
  logic                          s_wready;
  logic [ID_WIDTH-1:0]           s_bid;
  logic [1:0]                    s_bresp;
  logic                          s_bvalid;
  logic                          s_bready;

  // master: the surrounding system (requesting masters plus downstream slave); slave: the arbiter
  modport master (
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    input  m_awready, m_wready, m_bid, m_bresp, m_bvalid,
    input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot,
    input  s_awqos, s_awvalid, s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
    output s_awready, s_wready, s_bid, s_bresp, s_bvalid
  );

  modport slave (
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    output m_awready, m_wready, m_bid, m_bresp, m_bvalid,
    output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot,
    output s_awqos, s_awvalid, s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
    input  s_awready, s_wready, s_bid, s_bresp, s_bvalid
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester strictly after last_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned IdxW  = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IdxW-1:0]  last_ptr,
  output logic [NUM_M-1:0] grant,
  output logic [IdxW-1:0]  index
);

  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    grant = '0;
    index = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      cand = IdxW'((32'(last_ptr) + k) % NUM_M);
      if (!found && req[cand]) begin
        found        = 1'b1;
        grant[cand]  = 1'b1;
        index        = cand;
      end
    end
  end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// Round-robin AXI4 write-path arbiter: one master owns AW, W and B from grant until the B handshake.
module axi4_wr_arbiter
  import axi_parameters::*;
#(
  parameter int unsigned NUM_M = 2
) (
  input  logic             clock,
  input  logic             reset,
  axi4_wr_arbiter_if.slave bus,
  output logic [NUM_M-1:0] grant,
  output logic             busy,
  output logic             wlast_err
);

  localparam int unsigned IdxW  = $clog2(NUM_M);
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  arb_state_t       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [IdxW-1:0]  g_q, g_d;
  logic [IdxW-1:0]  last_ptr_q, last_ptr_d;
  logic [7:0]       awlen_q, awlen_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic [NUM_M-1:0] pick_grant;
  logic [IdxW-1:0]  pick_index;
  int unsigned      gi;
  logic             aw_hs, w_hs, b_hs;

  rr_pick #(
    .NUM_M (NUM_M),
    .IdxW  (IdxW)
  ) u_rr_pick (
    .req      (bus.m_awvalid),
    .last_ptr (last_ptr_q),
    .grant    (pick_grant),
    .index    (pick_index)
  );

  assign gi    = 32'(g_q);
  assign aw_hs = (state_q == ADDR) && bus.m_awvalid[g_q] && bus.s_awready;
  assign w_hs  = (state_q == DATA) && bus.m_wvalid[g_q] && bus.s_wready;
  assign b_hs  = (state_q == RESP) && bus.s_bvalid && bus.m_bready[g_q];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    g_d        = g_q;
    last_ptr_d = last_ptr_q;
    awlen_d    = awlen_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: if (|bus.m_awvalid) begin
        grant_d = pick_grant;
        g_d     = pick_index;
        state_d = ADDR;
      end
      ADDR: if (aw_hs) begin
        awlen_d    = bus.m_awlen[gi*8 +: 8];
        beat_cnt_d = '0;
        state_d    = DATA;
      end
      // Only WLAST ends the burst; a count mismatch is flagged, never enforced.
      DATA: if (w_hs) begin
        beat_cnt_d = beat_cnt_q + 8'd1;
        if (bus.m_wlast[g_q]) state_d = RESP;
      end
      RESP: if (b_hs) begin
        last_ptr_d = g_q;
        grant_d    = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      g_q        <= '0;
      last_ptr_q <= IdxW'(NUM_M - 1);
      awlen_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      g_q        <= g_d;
      last_ptr_q <= last_ptr_d;
      awlen_q    <= awlen_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    bus.m_awready = '0;
    bus.m_wready  = '0;
    bus.m_bvalid  = '0;
    bus.m_bid     = '0;
    bus.m_bresp   = '0;
    bus.s_awid    = '0;
    bus.s_awaddr  = '0;
    bus.s_awlen   = '0;
    bus.s_awsize  = '0;
    bus.s_awburst = '0;
    bus.s_awvalid = 1'b0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.s_wlast   = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    wlast_err     = 1'b0;
    unique case (state_q)
      ADDR: begin
        bus.s_awid         = bus.m_awid[gi*ID_WIDTH +: ID_WIDTH];
        bus.s_awaddr       = bus.m_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        bus.s_awlen        = bus.m_awlen[gi*8 +: 8];
        bus.s_awsize       = bus.m_awsize[gi*3 +: 3];
        bus.s_awburst      = bus.m_awburst[gi*2 +: 2];
        bus.s_awvalid      = bus.m_awvalid[g_q];
        bus.m_awready[g_q] = bus.s_awready;
      end
      DATA: begin
        bus.s_wdata       = bus.m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        bus.s_wstrb       = bus.m_wstrb[gi*StrbW +: StrbW];
        bus.s_wlast       = bus.m_wlast[g_q];
        bus.s_wvalid      = bus.m_wvalid[g_q];
        bus.m_wready[g_q] = bus.s_wready;
        wlast_err         = w_hs && (bus.m_wlast[g_q] != (beat_cnt_q == awlen_q));
      end
      RESP: begin
        bus.m_bvalid[g_q] = bus.s_bvalid;
        bus.s_bready      = bus.m_bready[g_q];
        bus.m_bid         = bus.s_bid;
        bus.m_bresp       = bus.s_bresp;
      end
      default: ;
    endcase
  end

  assign bus.s_awlock  = 1'b0;
  assign bus.s_awcache = 4'd0;
  assign bus.s_awprot  = 3'd0;
  assign bus.s_awqos   = 4'd0;

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule
